// File: rtl/change_dispenser_pkg.sv
// Shared types and coin constants for the change dispenser.
// Amounts are in half-farthing units: penny = 8, farthing = 2, half-farthing = 1.
package change_dispenser_pkg;

  typedef enum logic [1:0] {NONE, PEN, FA, HFA} coin_t;

  typedef enum logic [2:0] {IDLE, SELECT, PRESENT, GAP, FINISH} state_t;

  localparam int unsigned PEN_VAL = 8;
  localparam int unsigned FA_VAL  = 2;
  localparam int unsigned HFA_VAL = 1;

  function automatic int unsigned coin_value(input coin_t coin);
    case (coin)
      PEN:     coin_value = PEN_VAL;
      FA:      coin_value = FA_VAL;
      HFA:     coin_value = HFA_VAL;
      default: coin_value = 0;
    endcase
  endfunction

  // Greedy choice: largest coin that fits the remainder and is still in stock.
  function automatic coin_t pick_coin(input int unsigned rem, input logic pen_ok,
                                      input logic fa_ok, input logic hfa_ok);
    if (rem >= PEN_VAL && pen_ok)      pick_coin = PEN;
    else if (rem >= FA_VAL && fa_ok)   pick_coin = FA;
    else if (rem >= HFA_VAL && hfa_ok) pick_coin = HFA;
    else                               pick_coin = NONE;
  endfunction

endpackage

// File: rtl/change_dispenser_coin_stock_counter.sv
// Stock counter for one coin type: reloads to its initial value, counts down
// on each dispensed coin and never wraps below zero.
module coin_stock_counter #(
  parameter int WIDTH = 4,
  parameter int INIT  = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic decrement,
  output logic empty
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= WIDTH'(INIT);
    else if (reload)
      count <= WIDTH'(INIT);
    else if (decrement && count != '0)
      count <= count - 1'b1;
  end

  assign empty = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a loaded amount one coin at a time over a
// request/acknowledge handshake to the ejector, greedy with stock fallback.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W      = 5,
  parameter int STOCK_W    = 4,
  parameter int PEN_STOCK  = 15,
  parameter int FA_STOCK   = 15,
  parameter int HFA_STOCK  = 15,
  parameter int GAP_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             Load,
  input  logic [AMT_W-1:0] Amount,
  input  logic             Refill,
  input  logic             Eject_ack,
  output logic             Ready,
  output logic             Pen_out,
  output logic             Fa_out,
  output logic             HFa_out,
  output logic             Done,
  output logic             Short,
  output logic [AMT_W-1:0] Remaining
);

  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, next_state;
  coin_t            coin_reg, sel;
  logic [GAP_W-1:0] gap_cnt;
  logic [AMT_W-1:0] rem_after;
  logic             pen_empty, fa_empty, hfa_empty;
  logic             reload, paid;

  assign reload    = (state == IDLE) && Refill;
  assign paid      = (state == PRESENT) && Eject_ack;
  assign rem_after = Remaining - AMT_W'(coin_value(coin_reg));
  assign sel       = pick_coin(32'(Remaining), !pen_empty, !fa_empty, !hfa_empty);

  coin_stock_counter #(.WIDTH(STOCK_W), .INIT(PEN_STOCK)) pen_stock (
    .clk(CLK), .rst(RES), .reload(reload),
    .decrement(paid && coin_reg == PEN), .empty(pen_empty)
  );

  coin_stock_counter #(.WIDTH(STOCK_W), .INIT(FA_STOCK)) fa_stock (
    .clk(CLK), .rst(RES), .reload(reload),
    .decrement(paid && coin_reg == FA), .empty(fa_empty)
  );

  coin_stock_counter #(.WIDTH(STOCK_W), .INIT(HFA_STOCK)) hfa_stock (
    .clk(CLK), .rst(RES), .reload(reload),
    .decrement(paid && coin_reg == HFA), .empty(hfa_empty)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Load) next_state = (Amount == '0) ? FINISH : SELECT;
      SELECT:  next_state = (sel != NONE) ? PRESENT : FINISH;
      PRESENT: begin
        if (Eject_ack) begin
          if (rem_after == '0)     next_state = FINISH;
          else if (GAP_CYCLES > 0) next_state = GAP;
          else                     next_state = SELECT;
        end
      end
      GAP:     if (gap_cnt == GAP_LAST) next_state = SELECT;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Done and Short share FINISH; the leftover remainder tells them apart.
  always_comb begin
    Ready = 1'b0;
    Done  = 1'b0;
    Short = 1'b0;
    case (state)
      IDLE:    Ready = 1'b1;
      FINISH: begin
        Done  = (Remaining == '0);
        Short = (Remaining != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      Remaining <= '0;
      Pen_out   <= 1'b0;
      Fa_out    <= 1'b0;
      HFa_out   <= 1'b0;
    end else begin
      if (state == IDLE && Load)
        Remaining <= Amount;
      else if (paid)
        Remaining <= rem_after;

      if (state == SELECT) begin
        Pen_out <= (sel == PEN);
        Fa_out  <= (sel == FA);
        HFa_out <= (sel == HFA);
      end else if (paid) begin
        Pen_out <= 1'b0;
        Fa_out  <= 1'b0;
        HFa_out <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state == SELECT)
      coin_reg <= sel;
    gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy model queues the expected
// coin sequence at load time; each presented coin is popped and compared.
module tb_change_dispenser;

  localparam int AMT_W = 5;
  localparam int GAPC  = 2;
  localparam int P_INIT = 1, F_INIT = 4, H_INIT = 2;

  logic             CLK = 1'b0;
  logic             RES;
  logic             Load, Refill, Eject_ack;
  logic [AMT_W-1:0] Amount;
  logic             Ready, Pen_out, Fa_out, HFa_out, Done, Short;
  logic [AMT_W-1:0] Remaining;
  logic [2:0]       coins;

  int n_checks = 0;
  int n_fail   = 0;
  int st_p, st_f, st_h;
  logic [2:0] exp_q[$];

  change_dispenser #(
    .AMT_W(AMT_W), .STOCK_W(4), .PEN_STOCK(P_INIT), .FA_STOCK(F_INIT),
    .HFA_STOCK(H_INIT), .GAP_CYCLES(GAPC)
  ) dut (
    .CLK(CLK), .RES(RES), .Load(Load), .Amount(Amount), .Refill(Refill),
    .Eject_ack(Eject_ack), .Ready(Ready), .Pen_out(Pen_out), .Fa_out(Fa_out),
    .HFa_out(HFa_out), .Done(Done), .Short(Short), .Remaining(Remaining)
  );

  assign coins = {Pen_out, Fa_out, HFa_out};

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int cval(input logic [2:0] c);
    case (c)
      3'b100:  cval = 8;
      3'b010:  cval = 2;
      3'b001:  cval = 1;
      default: cval = 0;
    endcase
  endfunction

  task automatic model_refill();
    st_p = P_INIT;
    st_f = F_INIT;
    st_h = H_INIT;
  endtask

  task automatic run_payout(input int amt, input bit refill, input int hold);
    int r, rem_m, exp_rem;
    logic [2:0] exp_c;
    if (refill) model_refill();
    exp_q.delete();
    r = amt;
    forever begin
      if (r >= 8 && st_p > 0)      begin exp_q.push_back(3'b100); st_p--; r -= 8; end
      else if (r >= 2 && st_f > 0) begin exp_q.push_back(3'b010); st_f--; r -= 2; end
      else if (r >= 1 && st_h > 0) begin exp_q.push_back(3'b001); st_h--; r -= 1; end
      else break;
    end
    exp_rem = r;

    Amount = AMT_W'(amt);
    Load   = 1'b1;
    Refill = refill;
    tick();
    Load   = 1'b0;
    Refill = 1'b0;
    check_eq("ready_busy", Ready, 0);
    if (amt == 0) begin
      check_eq("zero_done", Done, 1);
      check_eq("zero_coins", coins, 0);
      tick();
      check_eq("zero_ready", Ready, 1);
      check_eq("zero_done_pulse", Done, 0);
      return;
    end
    tick();
    rem_m = amt;
    while (exp_q.size() > 0) begin
      exp_c = exp_q.pop_front();
      check_eq("coin", coins, exp_c);
      check_eq("rem_present", Remaining, rem_m);
      for (int i = 0; i < hold; i++) begin
        if (i == 3) begin
          Load   = 1'b1;
          Refill = 1'b1;
          Amount = 5'd31;
        end
        tick();
        Load   = 1'b0;
        Refill = 1'b0;
        check_eq("coin_held", coins, exp_c);
      end
      Eject_ack = 1'b1;
      tick();
      Eject_ack = 1'b0;
      rem_m -= cval(exp_c);
      check_eq("coin_cleared", coins, 0);
      check_eq("rem_ack", Remaining, rem_m);
      if (rem_m == 0) begin
        check_eq("done", Done, 1);
        check_eq("no_short", Short, 0);
        tick();
        check_eq("ready_after_done", Ready, 1);
        check_eq("done_pulse", Done, 0);
        return;
      end
      for (int i = 0; i < GAPC; i++) begin
        tick();
        check_eq("gap_idle", coins, 0);
      end
      tick();
    end
    check_eq("short", Short, 1);
    check_eq("no_done", Done, 0);
    check_eq("short_rem", Remaining, exp_rem);
    check_eq("short_coins", coins, 0);
    tick();
    check_eq("ready_after_short", Ready, 1);
    check_eq("short_pulse", Short, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RES = 1'b1;
    Load = 1'b0;
    Refill = 1'b0;
    Eject_ack = 1'b0;
    Amount = '0;
    model_refill();
    #12;
    check_eq("rst_ready", Ready, 1);
    check_eq("rst_coins", coins, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_short", Short, 0);
    check_eq("rst_rem", Remaining, 0);
    RES = 1'b0;
    tick();

    run_payout(11, 1'b0, 0);   // Pen, Fa, HFa
    run_payout(8, 1'b0, 0);    // pennies gone: Fa x3, HFa, short by 1
    run_payout(3, 1'b0, 0);    // everything empty: immediate short
    run_payout(0, 1'b1, 0);    // refill then zero amount
    run_payout(6, 1'b0, 20);   // long ack latency with ignored Load/Refill
    run_payout(14, 1'b1, 0);   // refill and load together
    run_payout(8, 1'b0, 0);    // penny empty: Fa, HFa, HFa, short by 4
    run_payout(0, 1'b1, 0);
    run_payout(8, 1'b0, 0);    // uses the only penny

    Amount = 5'd2;
    Load = 1'b1;
    tick();
    Load = 1'b0;
    tick();
    check_eq("pre_rst_coin", coins, 3'b010);
    #3;
    RES = 1'b1;
    #1;
    check_eq("async_rst_coin", coins, 0);
    check_eq("async_rst_ready", Ready, 1);
    check_eq("async_rst_rem", Remaining, 0);
    @(posedge CLK);
    #3;
    RES = 1'b0;
    check_eq("post_rst_done", Done, 0);
    check_eq("post_rst_short", Short, 0);
    model_refill();
    tick();

    run_payout(8, 1'b0, 0);    // penny stock restored by reset
    run_payout(0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
